// File: rtl/sbus_mem_resp.sv
// sbus_mem_resp: memory-module end of the SBUS core-memory request protocol.
//
// Accepts a quadword request from the MBOX, checks address parity and range, answers with
// ACKN, then streams read words (DATA_VALID) and/or absorbs write words. Read-pause-write
// (RD_RQ and WR_RQ both set) reads the requested slots and then writes the same slots in
// the same order. An out-of-range address gets no response at all so the MBOX NXM timer
// fires. The storage array holds 36 data bits plus the stored parity bit and is not cleared
// by reset.
//
// Ports:
//   clk           in   sole clock, rising edge
//   RESET_n       in   asynchronous active-low reset
//   START         in   request strobe, sampled only when idle
//   RD_RQ, WR_RQ  in   read / write request (both = read-pause-write)
//   RQ[0:3]       in   word-request mask, bit i = quadword slot i
//   ADR[14:35]    in   word address
//   ADR_PAR       in   address parity, odd over ADR+ADR_PAR
//   DATA_IN[0:35] in   write data
//   DATA_PAR_IN   in   write data parity, odd
//   ERR_CLR       in   clears ERROR
//   ACKN          out  one-cycle acknowledge
//   DATA_VALID    out  one cycle per read word
//   DATA_OUT      out  read data, held while DATA_VALID is low
//   DATA_PAR_OUT  out  stored parity of the read word
//   ADR_PAR_ERR   out  one-cycle pulse on bad address parity
//   ERROR         out  sticky write-data parity error
//   BUSY          out  request in progress

module sbus_mem_resp #(
  parameter int unsigned MEM_WORDS = 4096,  // multiple of 4, at least 8
  parameter int unsigned BASE      = 0,     // multiple of 4
  parameter int unsigned ACKN_DLY  = 2,     // >= 1
  parameter int unsigned RD_DLY    = 3      // >= 1
) (
  input  logic         clk,
  input  logic         RESET_n,
  input  logic         START,
  input  logic         RD_RQ,
  input  logic         WR_RQ,
  input  logic [0:3]   RQ,
  input  logic [14:35] ADR,
  input  logic         ADR_PAR,
  input  logic [0:35]  DATA_IN,
  input  logic         DATA_PAR_IN,
  input  logic         ERR_CLR,
  output logic         ACKN,
  output logic         DATA_VALID,
  output logic [0:35]  DATA_OUT,
  output logic         DATA_PAR_OUT,
  output logic         ADR_PAR_ERR,
  output logic         ERROR,
  output logic         BUSY
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned QW = AW - 2;

  typedef enum logic [2:0] {
    StIdle,
    StAckWait,
    StRdWait,
    StRdXfer,
    StWrXfer
  } state_e;

  // Storage: {data[0:35], parity}, data in bits 36:1, parity in bit 0.
  logic [36:0] mem [MEM_WORDS];

  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [QW-1:0]  qw_q, qw_d;       // quadword index within the array
  logic [1:0]     slot0_q, slot0_d; // first slot of the wrap-around order
  logic [3:0]     om_q, om_d;       // request mask in transfer order (bit k = k-th slot)
  logic [3:0]     rem_q, rem_d;     // slots still to transfer in the current pass
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;

  logic           ackn_q, ackn_d;
  logic           dv_q, dv_d;
  logic [0:35]    dout_q, dout_d;
  logic           dpar_q, dpar_d;
  logic           ape_q, ape_d;
  logic           busy_q, busy_d;
  logic           error_q, error_d;

  // Request decode, valid only while START is presented in idle.
  logic [31:0]    adr_off;
  logic           in_range;
  logic           adr_par_ok;
  logic [1:0]     adr_slot;
  logic [1:0]     adr_slot1, adr_slot2, adr_slot3;
  logic [3:0]     rq_ord;

  // Transfer sequencing.
  logic [1:0]     pick;
  logic [3:0]     rem_nxt;
  logic [1:0]     cur_slot;
  logic [AW-1:0]  cur_idx;
  logic [36:0]    rd_word;
  logic           wdata_par_ok;
  logic           mem_we;
  logic           err_set;

  // Offset wraps to a huge value when ADR < BASE, so one compare covers both bounds.
  assign adr_off    = 32'(ADR) - BASE;
  assign in_range   = adr_off < MEM_WORDS;
  assign adr_par_ok = ^{ADR, ADR_PAR};

  assign adr_slot  = ADR[34:35];
  assign adr_slot1 = adr_slot + 2'd1;
  assign adr_slot2 = adr_slot + 2'd2;
  assign adr_slot3 = adr_slot + 2'd3;

  // Rotate the slot mask so bit 0 is the addressed slot and later bits follow mod 4.
  assign rq_ord[0] = RQ[adr_slot];
  assign rq_ord[1] = RQ[adr_slot1];
  assign rq_ord[2] = RQ[adr_slot2];
  assign rq_ord[3] = RQ[adr_slot3];

  // Next slot = lowest pending bit of the ordered mask; unrequested slots are skipped so
  // transfers stay back-to-back.
  always_comb begin
    if (rem_q[0])      pick = 2'd0;
    else if (rem_q[1]) pick = 2'd1;
    else if (rem_q[2]) pick = 2'd2;
    else               pick = 2'd3;
  end

  assign rem_nxt      = rem_q & ~(4'b0001 << pick);
  assign cur_slot     = slot0_q + pick;
  assign cur_idx      = {qw_q, cur_slot};
  assign rd_word      = mem[cur_idx];
  assign wdata_par_ok = ^{DATA_IN, DATA_PAR_IN};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qw_d    = qw_q;
    slot0_d = slot0_q;
    om_d    = om_q;
    rem_d   = rem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ackn_d  = 1'b0;
    dv_d    = 1'b0;
    dout_d  = dout_q;
    dpar_d  = dpar_q;
    ape_d   = 1'b0;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    err_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          if (!adr_par_ok) begin
            ape_d = 1'b1;
          end else if (in_range) begin
            state_d = StAckWait;
            cnt_d   = 16'(ACKN_DLY - 1);
            qw_d    = adr_off[AW-1:2];
            slot0_d = adr_slot;
            om_d    = rq_ord;
            rd_d    = RD_RQ;
            wr_d    = WR_RQ;
            busy_d  = 1'b1;
          end
          // Out of range: stay silent so the requester times out.
        end
      end

      StAckWait: begin
        if (cnt_q == 16'd0) begin
          ackn_d = 1'b1;
          rem_d  = om_q;
          if ((om_q == 4'b0000) || (!rd_q && !wr_q)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else if (rd_q) begin
            state_d = StRdWait;
            cnt_d   = 16'(RD_DLY - 1);
          end else begin
            state_d = StWrXfer;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StRdWait, StRdXfer: begin
        if ((state_q == StRdWait) && (cnt_q != 16'd0)) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          // The edge that ends the access delay already drives the first word.
          dv_d   = 1'b1;
          dout_d = rd_word[36:1];
          dpar_d = rd_word[0];
          rem_d  = rem_nxt;
          if (rem_nxt == 4'b0000) begin
            if (wr_q) begin
              state_d = StWrXfer;
              rem_d   = om_q;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = StRdXfer;
          end
        end
      end

      StWrXfer: begin
        mem_we  = 1'b1;
        err_set = !wdata_par_ok;
        rem_d   = rem_nxt;
        if (rem_nxt == 4'b0000) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // A new error wins over a simultaneous clear.
    error_d = err_set | (error_q & ~ERR_CLR);
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qw_q    <= '0;
      slot0_q <= '0;
      om_q    <= '0;
      rem_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ackn_q  <= 1'b0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
      dpar_q  <= 1'b0;
      ape_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qw_q    <= qw_d;
      slot0_q <= slot0_d;
      om_q    <= om_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ackn_q  <= ackn_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
      dpar_q  <= dpar_d;
      ape_q   <= ape_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // Array contents survive reset; a reset forces idle, which stops further writes.
  // Bad-parity words are stored exactly as received.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= {DATA_IN, DATA_PAR_IN};
    end
  end

  assign ACKN         = ackn_q;
  assign DATA_VALID   = dv_q;
  assign DATA_OUT     = dout_q;
  assign DATA_PAR_OUT = dpar_q;
  assign ADR_PAR_ERR  = ape_q;
  assign ERROR        = error_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_sbus_mem_resp.sv
module tb_sbus_mem_resp;

  logic         clk = 1'b0;
  logic         RESET_n;
  logic         START;
  logic         RD_RQ;
  logic         WR_RQ;
  logic [0:3]   RQ;
  logic [14:35] ADR;
  logic         ADR_PAR;
  logic [0:35]  DATA_IN;
  logic         DATA_PAR_IN;
  logic         ERR_CLR;
  logic         ACKN;
  logic         DATA_VALID;
  logic [0:35]  DATA_OUT;
  logic         DATA_PAR_OUT;
  logic         ADR_PAR_ERR;
  logic         ERROR;
  logic         BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle observations; index c = sample taken 1 ns after edge E0+c.
  logic        o_ack  [64];
  logic        o_dv   [64];
  logic [35:0] o_dat  [64];
  logic        o_par  [64];
  logic        o_busy [64];
  logic        o_ape  [64];
  logic        o_err  [64];

  // Write words in transfer order: {data, parity}.
  logic [36:0] wbuf [4];

  always #5 clk = ~clk;

  sbus_mem_resp dut (
    .clk          (clk),
    .RESET_n      (RESET_n),
    .START        (START),
    .RD_RQ        (RD_RQ),
    .WR_RQ        (WR_RQ),
    .RQ           (RQ),
    .ADR          (ADR),
    .ADR_PAR      (ADR_PAR),
    .DATA_IN      (DATA_IN),
    .DATA_PAR_IN  (DATA_PAR_IN),
    .ERR_CLR      (ERR_CLR),
    .ACKN         (ACKN),
    .DATA_VALID   (DATA_VALID),
    .DATA_OUT     (DATA_OUT),
    .DATA_PAR_OUT (DATA_PAR_OUT),
    .ADR_PAR_ERR  (ADR_PAR_ERR),
    .ERROR        (ERROR),
    .BUSY         (BUSY)
  );

  function automatic logic [36:0] gw(input logic [35:0] d);
    return {d, ~^d};
  endfunction

  // Present one request, START seen at edge E0, and record ncyc samples.
  // The write word j is presented so that it is sampled at edge E0+wstart+j.
  // START stays high through edge E0+hold; ERR_CLR is high at edge E0+clr_edge.
  task automatic do_req(input logic [21:0] adr, input logic bad_par, input logic rd,
                        input logic wr, input logic [0:3] rq, input int wstart,
                        input int hold, input int clr_edge, input int ncyc);
    int j;
    ADR     = adr;
    ADR_PAR = bad_par ? ^adr : ~^adr;
    RD_RQ   = rd;
    WR_RQ   = wr;
    RQ      = rq;
    START   = 1'b1;
    ERR_CLR = (clr_edge == 0);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      o_ack[c]  = ACKN;
      o_dv[c]   = DATA_VALID;
      o_dat[c]  = DATA_OUT;
      o_par[c]  = DATA_PAR_OUT;
      o_busy[c] = BUSY;
      o_ape[c]  = ADR_PAR_ERR;
      o_err[c]  = ERROR;
      if (c >= hold) START = 1'b0;
      j = c + 1 - wstart;
      if (j >= 0 && j < 4) begin
        DATA_IN     = wbuf[j][36:1];
        DATA_PAR_IN = wbuf[j][0];
      end
      ERR_CLR = (c + 1 == clr_edge);
    end
    START   = 1'b0;
    ERR_CLR = 1'b0;
    RD_RQ   = 1'b0;
    WR_RQ   = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ADR_PAR_ERR, ERROR, BUSY} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ADR_PAR_ERR, ERROR, BUSY});
    end
    RESET_n = 1'b1;
    // Read in flight, reset asserted in the middle of the data phase.
    do_req(22'o10, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 0, -1, 6);
    n_cmp++;
    if (o_dv[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_dv: got %b want 1", o_dv[5]);
    end
    RESET_n = 1'b0;
    #1;
    n_cmp++;
    if ({ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ADR_PAR_ERR, ERROR, BUSY} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_midread: got %h want 0",
               {ACKN, DATA_VALID, DATA_OUT, DATA_PAR_OUT, ADR_PAR_ERR, ERROR, BUSY});
    end
    #2;
    RESET_n = 1'b1;
    // Fresh request after reset, slot 0 only.
    do_req(22'o10, 1'b0, 1'b1, 1'b0, 4'b1000, 99, 0, -1, 8);
    n_cmp++;
    if ({o_ack[1], o_ack[2], o_ack[3]} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_next_ackn: got %b want 010", {o_ack[1], o_ack[2], o_ack[3]});
    end
    n_cmp++;
    if ({o_dv[4], o_dv[5], o_dv[6]} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_next_dv: got %b want 010", {o_dv[4], o_dv[5], o_dv[6]});
    end
    n_cmp++;
    if ({o_busy[0], o_busy[4], o_busy[5]} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_next_busy: got %b want 110", {o_busy[0], o_busy[4], o_busy[5]});
    end
  endtask

  task automatic test_write_read;
    int ndv;
    wbuf[0] = gw(36'd1);
    wbuf[1] = gw(36'd2);
    wbuf[2] = gw(36'd3);
    wbuf[3] = gw(36'd4);
    // 0o102 -> slots 2,3,0,1; words sampled at edges E0+3..E0+6.
    do_req(22'o102, 1'b0, 1'b0, 1'b1, 4'b1111, 3, 0, -1, 10);
    ndv = 0;
    for (int c = 0; c < 10; c++) ndv += int'(o_dv[c]);
    n_cmp++;
    if ({o_ack[1], o_ack[2], o_ack[3]} !== 3'b010) begin
      n_fail++;
      $display("FAIL wr_ackn: got %b want 010", {o_ack[1], o_ack[2], o_ack[3]});
    end
    n_cmp++;
    if ({o_busy[0], o_busy[5], o_busy[6]} !== 3'b110) begin
      n_fail++;
      $display("FAIL wr_busy: got %b want 110", {o_busy[0], o_busy[5], o_busy[6]});
    end
    n_cmp++;
    if (ndv !== 0 || o_err[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_no_dv_err: got dv=%0d err=%b want 0 0", ndv, o_err[9]);
    end
    do_req(22'o102, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 0, -1, 12);
    n_cmp++;
    if ({o_dv[4], o_dv[5], o_dv[6], o_dv[7], o_dv[8], o_dv[9]} !== 6'b011110) begin
      n_fail++;
      $display("FAIL rd_dv_timing: got %b want 011110",
               {o_dv[4], o_dv[5], o_dv[6], o_dv[7], o_dv[8], o_dv[9]});
    end
    n_cmp++;
    if ({o_dat[5], o_dat[6], o_dat[7], o_dat[8]} !== {36'd1, 36'd2, 36'd3, 36'd4}) begin
      n_fail++;
      $display("FAIL rd_data: got %0d %0d %0d %0d want 1 2 3 4",
               o_dat[5], o_dat[6], o_dat[7], o_dat[8]);
    end
    n_cmp++;
    if ({o_par[5], o_par[6], o_par[7], o_par[8]} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rd_parity: got %b want 0010", {o_par[5], o_par[6], o_par[7], o_par[8]});
    end
    n_cmp++;
    if (o_dat[11] !== 36'd4) begin
      n_fail++;
      $display("FAIL rd_data_hold: got %0d want 4", o_dat[11]);
    end
    n_cmp++;
    if ({o_busy[7], o_busy[8]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_busy_end: got %b want 10", {o_busy[7], o_busy[8]});
    end
  endtask

  task automatic test_nxm;
    int nack;
    int ndv;
    int nbusy;
    do_req(22'o10000, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 0, -1, 64);
    nack = 0;
    ndv = 0;
    nbusy = 0;
    for (int c = 0; c < 64; c++) begin
      nack  += int'(o_ack[c]);
      ndv   += int'(o_dv[c]);
      nbusy += int'(o_busy[c]);
    end
    n_cmp++;
    if (nack !== 0 || ndv !== 0 || nbusy !== 0) begin
      n_fail++;
      $display("FAIL nxm_silent: got ack=%0d dv=%0d busy=%0d want 0 0 0", nack, ndv, nbusy);
    end
    // Last implemented word, slot 3 only, is served.
    do_req(22'o7777, 1'b0, 1'b1, 1'b0, 4'b0001, 99, 0, -1, 8);
    n_cmp++;
    if ({o_ack[2], o_dv[5], o_dv[6]} !== 3'b110) begin
      n_fail++;
      $display("FAIL top_word: got %b want 110", {o_ack[2], o_dv[5], o_dv[6]});
    end
  endtask

  task automatic test_adr_par;
    int nack;
    wbuf[0] = gw(36'o777777777777);
    wbuf[1] = gw(36'o777777777777);
    wbuf[2] = gw(36'o777777777777);
    wbuf[3] = gw(36'o777777777777);
    do_req(22'o100, 1'b1, 1'b0, 1'b1, 4'b1111, 3, 0, -1, 10);
    nack = 0;
    for (int c = 0; c < 10; c++) nack += int'(o_ack[c]);
    n_cmp++;
    if ({o_ape[0], o_ape[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL ape_pulse: got %b want 10", {o_ape[0], o_ape[1]});
    end
    n_cmp++;
    if (nack !== 0 || o_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ape_no_ack: got ack=%0d busy=%b want 0 0", nack, o_busy[0]);
    end
    // Slot order 0,1,2,3 at 0o100 holds 3,4,1,2 from the earlier write.
    do_req(22'o100, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 0, -1, 10);
    n_cmp++;
    if ({o_dat[5], o_dat[6], o_dat[7], o_dat[8]} !== {36'd3, 36'd4, 36'd1, 36'd2}) begin
      n_fail++;
      $display("FAIL ape_unchanged: got %0d %0d %0d %0d want 3 4 1 2",
               o_dat[5], o_dat[6], o_dat[7], o_dat[8]);
    end
  endtask

  task automatic test_rpw;
    int nack;
    wbuf[0] = gw(36'o100);
    wbuf[1] = gw(36'o101);
    wbuf[2] = gw(36'o102);
    wbuf[3] = gw(36'o103);
    do_req(22'o20, 1'b0, 1'b0, 1'b1, 4'b1111, 3, 0, -1, 8);
    wbuf[0] = gw(36'o200);
    wbuf[1] = gw(36'o202);
    // Slots 0 and 2: reads at E0+5, E0+6; writes sampled at E0+7, E0+8.
    do_req(22'o20, 1'b0, 1'b1, 1'b1, 4'b1010, 7, 0, -1, 12);
    nack = 0;
    for (int c = 0; c < 12; c++) nack += int'(o_ack[c]);
    n_cmp++;
    if ({o_dv[4], o_dv[5], o_dv[6], o_dv[7]} !== 4'b0110 || nack !== 1) begin
      n_fail++;
      $display("FAIL rpw_dv: got dv=%b ack=%0d want 0110 1",
               {o_dv[4], o_dv[5], o_dv[6], o_dv[7]}, nack);
    end
    n_cmp++;
    if ({o_dat[5], o_dat[6]} !== {36'o100, 36'o102}) begin
      n_fail++;
      $display("FAIL rpw_old_data: got %o %o want 100 102", o_dat[5], o_dat[6]);
    end
    n_cmp++;
    if ({o_busy[7], o_busy[8]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rpw_busy: got %b want 10", {o_busy[7], o_busy[8]});
    end
    do_req(22'o20, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 0, -1, 10);
    n_cmp++;
    if ({o_dat[5], o_dat[6], o_dat[7], o_dat[8]} !== {36'o200, 36'o101, 36'o202, 36'o103})
    begin
      n_fail++;
      $display("FAIL rpw_new_data: got %o %o %o %o want 200 101 202 103",
               o_dat[5], o_dat[6], o_dat[7], o_dat[8]);
    end
  endtask

  task automatic test_error;
    // 5 has two ones, so odd parity needs 1; store 0 instead.
    wbuf[0] = {36'd5, 1'b0};
    do_req(22'o30, 1'b0, 1'b0, 1'b1, 4'b1000, 3, 0, -1, 6);
    n_cmp++;
    if ({o_err[2], o_err[3], o_busy[3]} !== 3'b010) begin
      n_fail++;
      $display("FAIL err_set: got %b want 010", {o_err[2], o_err[3], o_busy[3]});
    end
    do_req(22'o30, 1'b0, 1'b1, 1'b0, 4'b1000, 99, 0, -1, 8);
    n_cmp++;
    if ({o_dv[5], o_dat[5], o_par[5], o_err[5]} !== {1'b1, 36'd5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL err_readback: got dv=%b d=%0d p=%b e=%b want 1 5 0 1",
               o_dv[5], o_dat[5], o_par[5], o_err[5]);
    end
    ERR_CLR = 1'b1;
    @(posedge clk);
    #1;
    ERR_CLR = 1'b0;
    n_cmp++;
    if (ERROR !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", ERROR);
    end
    // Second bad word written at E0+3 with ERR_CLR high at the same edge.
    wbuf[0] = {36'd5, 1'b0};
    do_req(22'o30, 1'b0, 1'b0, 1'b1, 4'b1000, 3, 0, 3, 6);
    n_cmp++;
    if ({o_err[2], o_err[3]} !== 2'b01) begin
      n_fail++;
      $display("FAIL err_set_wins: got %b want 01", {o_err[2], o_err[3]});
    end
    ERR_CLR = 1'b1;
    @(posedge clk);
    #1;
    ERR_CLR = 1'b0;
  endtask

  task automatic test_busy_start;
    int nack;
    int ndv;
    // START held high through edge E0+7 while the read is still busy.
    do_req(22'o102, 1'b0, 1'b1, 1'b0, 4'b1111, 99, 7, -1, 20);
    nack = 0;
    ndv = 0;
    for (int c = 0; c < 20; c++) begin
      nack += int'(o_ack[c]);
      ndv  += int'(o_dv[c]);
    end
    n_cmp++;
    if (nack !== 1 || ndv !== 4) begin
      n_fail++;
      $display("FAIL busy_start: got ack=%0d dv=%0d want 1 4", nack, ndv);
    end
    n_cmp++;
    if (o_dat[8] !== 36'd4 || o_busy[19] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_end: got d=%0d busy=%b want 4 0", o_dat[8], o_busy[19]);
    end
  endtask

  initial begin
    RESET_n     = 1'b0;
    START       = 1'b0;
    RD_RQ       = 1'b0;
    WR_RQ       = 1'b0;
    RQ          = 4'b0000;
    ADR         = '0;
    ADR_PAR     = 1'b1;
    DATA_IN     = '0;
    DATA_PAR_IN = 1'b1;
    ERR_CLR     = 1'b0;
    test_reset;
    test_write_read;
    test_nxm;
    test_adr_par;
    test_rpw;
    test_error;
    test_busy_start;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
